muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit for the single-cycle core.
- Consumes the register file read operands (rd1/rd2) and produces a write-back triple (we/ad/wd) that feeds the register file write port (we3/ad3/wd3).
- Core stalls on busy. The block owns the write port for the single cycle in which done is high.

Parameters:
- A_WIDTH, 5, register address width (wb_ad, rd).
- D_WIDTH, 32, operand/result width; iteration count equals D_WIDTH.

Ports:
- clk  in  1  core clock, rising-edge sequential.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- rs1_val  in  D_WIDTH  operand A (rd1).
- rs2_val  in  D_WIDTH  operand B (rd2).
- rd  in  A_WIDTH  destination register.
- flush  in  1  synchronous abort of the in-flight op.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle result-valid pulse.
- wb_we  out  1  write enable to the register file; equals done.
- wb_ad  out  A_WIDTH  captured rd.
- wb_wd  out  D_WIDTH  result; valid only while done=1, 0 otherwise.

Behaviour:
- Reset: state IDLE; busy, done, wb_we = 0; wb_ad = 0; wb_wd = 0; all internal registers 0. Reset asserted mid-op aborts immediately with no done.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at a rising edge captures op, rs1_val, rs2_val and rd.
  - Special case -> DONE; otherwise -> CALC with count=0.
  - start=0 stays IDLE.
- CALC:
  - One radix-2 step per cycle; count increments.
  - After step D_WIDTH-1 -> DONE.
  - Latency: start edge to done cycle = D_WIDTH+1 cycles (33 at default).
- DONE: done=1 and wb_we=1 for exactly one cycle, then -> IDLE. A new start is accepted at the DONE->IDLE edge only if the input is re-sampled in IDLE, so back-to-back ops are spaced by at least one IDLE cycle.
- start while busy: ignored, no side effects.
- flush:
  - In CALC or DONE: forces IDLE at the next edge and suppresses done. A flush in the DONE cycle itself does not retract the done already visible.
  - Flush and start in the same IDLE cycle: flush wins, nothing captured.
- Multiply:
  - Form magnitudes according to op signedness: MULH treats both operands as signed, MULHSU treats rs1 as signed and rs2 as unsigned, MUL/MULHU use unsigned.
  - Shift-add into a 2*D_WIDTH product, then negate if the sign flag is set.
  - MUL returns the low D_WIDTH bits; the others return the high D_WIDTH bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases (1-cycle, no CALC):
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1_val.
  - Signed overflow, rs1 = 0x80000000 and rs2 = -1: DIV -> 0x80000000; REM -> 0.
- rd=0: done/wb_we still asserted; the register file discards writes to x0.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: the four multiply ops compute combinationally from the captured operands and go IDLE->DONE, giving 1-cycle latency. Divide behaviour is unchanged.
- Undefined: multiplies use the D_WIDTH-cycle shift-add path described above.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op enum with funct3 encodings 000-111,
  - the state enum (IDLE/CALC/DONE),
  - constants for the overflow dividend (0x80000000) and the div-by-zero quotient (all ones).
- One natural sub-module: div_iter, the restoring-divider step datapath (remainder/quotient shift, subtract, restore).
- Multiply step, sign fix-up and FSM stay in muldiv_unit.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD (-3), rd=5 -> busy for 33 cycles; done on cycle 33 with wb_we=1, wb_ad=5, wb_wd=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each done 1 cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Second start during CALC ignored and first result unaffected; flush at CALC cycle 10 -> IDLE next cycle with no done; subsequent start completes normally.
- rst pulsed mid-CALC -> busy/done/wb_we/wb_wd=0 immediately; no write-back after release; with MULDIV_FAST_MUL_EN, MUL 6*7 -> done 1 cycle after start with wb_wd=42.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    // funct3 encodings of the M extension
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          XLEN             = 32;
    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] DIV_ZERO_QUO     = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// One restoring-division step: shift remainder/quotient left, trial subtract, restore on borrow.
module div_iter #(
    parameter int D_WIDTH = 32
) (
    input  logic [D_WIDTH-1:0] rem_i,
    input  logic [D_WIDTH-1:0] quo_i,
    input  logic [D_WIDTH-1:0] divisor_i,
    output logic [D_WIDTH-1:0] rem_o,
    output logic [D_WIDTH-1:0] quo_o
);

    logic [D_WIDTH:0] shifted;
    logic [D_WIDTH:0] diff;

    // The remainder stays below the divisor, so one extra bit holds the shifted value and the borrow.
    always_comb begin
        shifted = {rem_i, quo_i[D_WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        if (diff[D_WIDTH]) begin
            rem_o = shifted[D_WIDTH-1:0];
            quo_o = {quo_i[D_WIDTH-2:0], 1'b0};
        end else begin
            rem_o = diff[D_WIDTH-1:0];
            quo_o = {quo_i[D_WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with register-file write-back outputs.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [D_WIDTH-1:0] rs1_val,
    input  logic [D_WIDTH-1:0] rs2_val,
    input  logic [A_WIDTH-1:0] rd,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic               wb_we,
    output logic [A_WIDTH-1:0] wb_ad,
    output logic [D_WIDTH-1:0] wb_wd
);

    localparam int            CW   = $clog2(D_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(D_WIDTH - 1);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [A_WIDTH-1:0]   rd_q, rd_d;
    logic [D_WIDTH-1:0]   hi_q, hi_d;
    logic [D_WIDTH-1:0]   lo_q, lo_d;
    logic [D_WIDTH-1:0]   opnd_q, opnd_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [D_WIDTH-1:0]   wb_wd_q, wb_wd_d;

    op_e                  op_in;
    logic                 a_sgn, b_sgn, sa, sb;
    logic [D_WIDTH-1:0]   a_mag, b_mag;
    logic                 div_zero, div_ovf;
    logic [D_WIDTH-1:0]   special_res;
    logic [D_WIDTH:0]     mul_sum;
    logic [D_WIDTH-1:0]   mul_hi_n, mul_lo_n;
    logic [D_WIDTH-1:0]   div_rem_n, div_quo_n;
    logic [2*D_WIDTH-1:0] prod_fix;
    logic [D_WIDTH-1:0]   quo_fix, rem_fix;
    logic [D_WIDTH-1:0]   final_res;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*D_WIDTH-1:0] a_ext, b_ext, prod_fast;
    logic [D_WIDTH-1:0]   fast_res;
`endif

    div_iter #(.D_WIDTH(D_WIDTH)) u_div_iter (
        .rem_i     (hi_q),
        .quo_i     (lo_q),
        .divisor_i (opnd_q),
        .rem_o     (div_rem_n),
        .quo_o     (div_quo_n)
    );

    // Operand decode: magnitudes, result signs and the single-cycle special cases.
    always_comb begin
        op_in    = op_e'(op);
        a_sgn    = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_sgn    = op_in inside {OP_MULH, OP_DIV, OP_REM};
        sa       = a_sgn & rs1_val[D_WIDTH-1];
        sb       = b_sgn & rs2_val[D_WIDTH-1];
        a_mag    = sa ? -rs1_val : rs1_val;
        b_mag    = sb ? -rs2_val : rs2_val;
        div_zero = op[2] && (rs2_val == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (rs1_val == DIV_OVF_DIVIDEND)
                   && (rs2_val == '1);
        special_res = '0;
        if (div_zero)
            special_res = op[1] ? rs1_val : DIV_ZERO_QUO;
        else if (div_ovf)
            special_res = op[1] ? '0 : DIV_OVF_DIVIDEND;
    end

    // Shift-add multiply step and sign fix-up of the value the last step produces.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_n  = mul_sum[D_WIDTH:1];
        mul_lo_n  = {mul_sum[0], lo_q[D_WIDTH-1:1]};
        prod_fix  = neg_q ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
        quo_fix   = neg_q ? -div_quo_n : div_quo_n;
        rem_fix   = rneg_q ? -div_rem_n : div_rem_n;
        final_res = '0;
        case (op_q)
            OP_MUL:                         final_res = prod_fix[D_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   final_res = prod_fix[2*D_WIDTH-1:D_WIDTH];
            OP_DIV, OP_DIVU:                final_res = quo_fix;
            OP_REM, OP_REMU:                final_res = rem_fix;
            default:                        final_res = '0;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extending to twice the width makes a plain product correct modulo 2^(2*D_WIDTH).
    always_comb begin
        a_ext     = {{D_WIDTH{sa ? 1'b1 : 1'b0}}, rs1_val};
        b_ext     = {{D_WIDTH{sb ? 1'b1 : 1'b0}}, rs2_val};
        prod_fast = a_ext * b_ext;
        fast_res  = (op_in == OP_MUL) ? prod_fast[D_WIDTH-1:0]
                                      : prod_fast[2*D_WIDTH-1:D_WIDTH];
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wb_wd_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d    = op_in;
                    rd_d    = rd;
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    count_d = '0;
                    hi_d    = '0;
                    opnd_d  = op[2] ? b_mag : a_mag;
                    lo_d    = op[2] ? a_mag : b_mag;
                    busy_d  = 1'b1;
                    if (div_zero || div_ovf) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        wb_wd_d = special_res;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!op[2]) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        wb_wd_d = fast_res;
`endif
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    hi_d    = op_q[2] ? div_rem_n : mul_hi_n;
                    lo_d    = op_q[2] ? div_quo_n : mul_lo_n;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        wb_wd_d = final_res;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MUL;
            rd_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wb_wd_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wb_wd_q <= wb_wd_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign wb_we = done_q;
    assign wb_ad = rd_q;
    assign wb_wd = wb_wd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; multiply latency follows MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        flush;
    logic        busy;
    logic        done;
    logic        wb_we;
    logic [4:0]  wb_ad;
    logic [31:0] wb_wd;

    int checks   = 0;
    int failures = 0;
    int cycles;
    int done_seen;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_unit #(.A_WIDTH(5), .D_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd      (rd),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .wb_we   (wb_we),
        .wb_ad   (wb_ad),
        .wb_wd   (wb_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present a start for one cycle; returns at the negedge after the capturing edge.
    task automatic applyStimulus(input op_e o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] d);
        @(negedge clk);
        op      = o;
        rs1_val = a;
        rs2_val = b;
        rd      = d;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic watchNoDone(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || wb_we !== 1'b0) seen++;
        end
    endtask

    task automatic runOp(input string tag, input op_e o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d,
                         input logic [31:0] exp_wd, input int exp_lat);
        applyStimulus(o, a, b, d);
        waitDone(cycles);
        checkOutput({tag, "_lat"}, 32'(cycles), 32'(exp_lat));
        checkOutput({tag, "_wd"}, wb_wd, exp_wd);
        checkOutput({tag, "_we"}, {31'd0, wb_we}, 32'd1);
        checkOutput({tag, "_ad"}, {27'd0, wb_ad}, {27'd0, d});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; rs1_val = '0; rs2_val = '0; rd = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_we", {31'd0, wb_we}, 32'd0);
        checkOutput("rst_ad", {27'd0, wb_ad}, 32'd0);
        checkOutput("rst_wd", wb_wd, 32'd0);
        rst = 1'b0;

        applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        checkOutput("mul_busy_c1", {31'd0, busy}, 32'd1);
        waitDone(cycles);
        checkOutput("mul_lat", 32'(cycles), 32'(MUL_LAT));
        checkOutput("mul_wd", wb_wd, 32'hFFFF_FFEB);
        checkOutput("mul_we", {31'd0, wb_we}, 32'd1);
        checkOutput("mul_ad", {27'd0, wb_ad}, 32'd5);
        @(negedge clk);
        checkOutput("mul_after_done", {31'd0, done}, 32'd0);
        checkOutput("mul_after_busy", {31'd0, busy}, 32'd0);
        checkOutput("mul_after_wd", wb_wd, 32'd0);

        runOp("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, MUL_LAT);
        runOp("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, MUL_LAT);
        runOp("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, MUL_LAT);
        runOp("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD, DIV_LAT);
        runOp("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF, DIV_LAT);
        runOp("divu",   OP_DIVU,   32'd100,       32'd7,         5'd7, 32'd14,        DIV_LAT);
        runOp("remu",   OP_REMU,   32'd100,       32'd7,         5'd8, 32'd2,         DIV_LAT);
        runOp("div0",   OP_DIV,    32'd5,         32'd0,         5'd9, 32'hFFFF_FFFF, 1);
        runOp("rem0",   OP_REM,    32'd5,         32'd0,         5'd10, 32'd5,        1);
        runOp("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
        runOp("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,        1);
        runOp("rd0",    OP_DIVU,   32'd9,         32'd0,         5'd0, 32'hFFFF_FFFF, 1);
        runOp("mul67",  OP_MUL,    32'd6,         32'd7,         5'd13, 32'd42,       MUL_LAT);

        // A second start in CALC must not disturb the first operation.
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd3);
        repeat (3) @(negedge clk);
        op = OP_MUL; rs1_val = 32'd1; rs2_val = 32'd1; rd = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(cycles);
        cycles += 4;
        checkOutput("ign_lat", 32'(cycles), 32'(DIV_LAT));
        checkOutput("ign_wd", wb_wd, 32'd14);
        checkOutput("ign_ad", {27'd0, wb_ad}, 32'd3);

        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", {31'd0, busy}, 32'd0);
        watchNoDone(40, done_seen);
        checkOutput("flush_no_done", 32'(done_seen), 32'd0);
        runOp("post_flush", OP_REMU, 32'd100, 32'd7, 5'd14, 32'd2, DIV_LAT);

        @(negedge clk);
        op = OP_DIV; rs1_val = 32'd5; rs2_val = 32'd0; rd = 5'd15; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checkOutput("flush_start_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_start_done", {31'd0, done}, 32'd0);

        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd16);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstmid_done", {31'd0, done}, 32'd0);
        checkOutput("rstmid_we", {31'd0, wb_we}, 32'd0);
        checkOutput("rstmid_wd", wb_wd, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        watchNoDone(40, done_seen);
        checkOutput("rstmid_no_done", 32'(done_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
